// File: rtl/universal_shift_register.sv
// universal_shift_register: parametrised hold/load/shift/rotate/clear register with serial word counter
module universal_shift_register #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);
  logic [WIDTH-1:0] shl, shr, rol, ror, q_nxt;
  logic shift_op, clr_cnt, last;
  generate
    if (WIDTH == 1) begin : g_one
      assign shl = sin_l;
      assign shr = sin_r;
      assign rol = q;
      assign ror = q;
    end else begin : g_wide
      assign shl = {q[WIDTH-2:0], sin_l};
      assign shr = {sin_r, q[WIDTH-1:1]};
      assign rol = {q[WIDTH-2:0], q[WIDTH-1]};
      assign ror = {q[0], q[WIDTH-1:1]};
    end
  endgenerate
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
  // shift class is exactly the modes where mode[2] and mode[1] differ
  always_comb begin
    shift_op = mode[2] ^ mode[1];
    clr_cnt  = (mode == 3'b001) || (mode == 3'b110);
    last     = shift_cnt == CNT_W'(WIDTH - 1);
    q_nxt    = mode == 3'b001 ? d :
               mode == 3'b010 ? shl :
               mode == 3'b011 ? shr :
               mode == 3'b100 ? rol :
               mode == 3'b101 ? ror :
               mode == 3'b110 ? '0 : q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= RESET_VALUE;
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else if (en) begin
      q         <= q_nxt;
      word_done <= shift_op && last;
      shift_cnt <= shift_op ? (last ? '0 : shift_cnt + CNT_W'(1)) : (clr_cnt ? '0 : shift_cnt);
    end else begin
      word_done <= 1'b0;
    end
  end
endmodule
